// File: rtl/oh_stimulus_mc_pkg.sv
// Shared constants for the multi-channel stimulus driver: modes, channel FSM
// states, entry field offsets and a channel-index width helper.
package oh_stimulus_mc_pkg;

  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_PLAY = 2'd1;
  localparam logic [1:0] MODE_LOOP = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Entry layout {payload, delay, valid}; payload starts at bit CW.
  localparam int E_VLD = 0;
  localparam int E_DLY = 1;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oh_stimulus_mc_if.sv
// Load and stimulus bus of oh_stimulus_mc. slave = stimulus block side,
// master = host/loader plus DUT side.
interface oh_stimulus_mc_if import oh_stimulus_mc_pkg::*; #(
  parameter int NCH = 4,
  parameter int PW  = 32,
  parameter int CW  = 8
) ();
  localparam int CHW = chan_w(NCH);
  localparam int EW  = PW + CW;

  logic [1:0]        mode;
  logic              load_valid;
  logic [CHW-1:0]    load_chan;
  logic [EW-1:0]     load_entry;
  logic              load_clear;
  logic [NCH-1:0]    load_full;
  logic [NCH-1:0]    stim_valid;
  logic [NCH*PW-1:0] stim_packet;
  logic [NCH-1:0]    stim_ready;
  logic [NCH-1:0]    stim_done;
  logic              all_done;

  modport slave (
    input  mode, load_valid, load_chan, load_entry, load_clear, stim_ready,
    output load_full, stim_valid, stim_packet, stim_done, all_done
  );

  modport master (
    output mode, load_valid, load_chan, load_entry, load_clear, stim_ready,
    input  load_full, stim_valid, stim_packet, stim_done, all_done
  );
endinterface

// File: rtl/oh_stimulus_chan.sv
// One playback channel: entry memory, write counter and the
// IDLE/FETCH/WAIT/SEND/DONE sequencer with valid/ready output.
module oh_stimulus_chan import oh_stimulus_mc_pkg::*; #(
  parameter int PW    = 32,
  parameter int CW    = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [1:0]       mode,
  input  logic             wr_en,
  input  logic             clear,
  input  logic [PW+CW-1:0] wr_entry,
  input  logic             ready,
  output logic             valid,
  output logic [PW-1:0]    packet,
  output logic             done,
  output logic             full
);
  localparam int MAW = $clog2(DEPTH);
  localparam int EW  = PW + CW;
  localparam int DW  = CW - 1;

  logic [EW-1:0]  mem [DEPTH];
  logic [MAW:0]   wr_cnt;
  logic [MAW-1:0] rd_addr;
  logic [DW-1:0]  dcnt;
  logic [2:0]     state;

  logic [EW-1:0]  ent;
  logic [DW-1:0]  dly;
  logic           run, loop, e_end, loop_ok, last, we;

  assign run     = (mode == MODE_PLAY) || (mode == MODE_LOOP);
  assign loop    = (mode == MODE_LOOP);
  assign ent     = mem[rd_addr];
  assign dly     = ent[E_DLY +: DW];
  assign e_end   = ({1'b0, rd_addr} == wr_cnt) || !ent[E_VLD];
  // A loop restart needs at least one playable entry, else it would spin in FETCH.
  assign loop_ok = (wr_cnt != '0) && mem[0][E_VLD];
  assign last    = (rd_addr == MAW'(DEPTH - 1));
  assign full    = (wr_cnt == (MAW+1)'(DEPTH));
  assign we      = (mode == MODE_LOAD) && wr_en && !clear && !full;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      wr_cnt <= '0;
    else if (mode == MODE_LOAD) begin
      if (clear)   wr_cnt <= '0;
      else if (we) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_cnt[MAW-1:0]] <= wr_entry;
  end

  // HOLD is the fall-through case: nothing below runs, so state, rd_addr and dcnt freeze.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      dcnt    <= '0;
    end else if (mode == MODE_LOAD) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      dcnt    <= '0;
    end else if (run) begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: begin
          if (e_end) begin
            if (loop && loop_ok) rd_addr <= '0;
            else                 state   <= ST_DONE;
          end else if (dly == '0) begin
            state <= ST_SEND;
          end else begin
            state <= ST_WAIT;
            dcnt  <= dly;
          end
        end
        ST_WAIT: begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == DW'(1)) state <= ST_SEND;
        end
        ST_SEND: begin
          if (ready) begin
            rd_addr <= rd_addr + 1'b1;
            state   <= (last && !loop) ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign valid  = run && (state == ST_SEND);
  assign packet = valid ? ent[EW-1:CW] : '0;
  assign done   = (state == ST_DONE) && (mode == MODE_PLAY);

endmodule

// File: rtl/oh_stimulus_mc.sv
// Multi-channel stimulus driver top: load-channel decode, one
// oh_stimulus_chan per channel, output packing and all_done.
module oh_stimulus_mc import oh_stimulus_mc_pkg::*; #(
  parameter int NCH   = 4,
  parameter int PW    = 32,
  parameter int CW    = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           nreset,
  oh_stimulus_mc_if.slave bus
);
  localparam int CHW = chan_w(NCH);

  logic [NCH-1:0][PW-1:0] pkt;
  logic [NCH-1:0]         valid, done, full;

  // load_chan values >= NCH match no instance and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    oh_stimulus_chan #(
      .PW    (PW),
      .CW    (CW),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk      (clk),
      .nreset   (nreset),
      .mode     (bus.mode),
      .wr_en    (bus.load_valid && (bus.load_chan == CHW'(i))),
      .clear    (bus.load_clear),
      .wr_entry (bus.load_entry),
      .ready    (bus.stim_ready[i]),
      .valid    (valid[i]),
      .packet   (pkt[i]),
      .done     (done[i]),
      .full     (full[i])
    );
  end

  assign bus.stim_valid  = valid;
  assign bus.stim_packet = pkt;
  assign bus.stim_done   = done;
  assign bus.load_full   = full;
  assign bus.all_done    = &done;

endmodule

// File: tb/tb_oh_stimulus_mc.sv
// Directed-vector bench for oh_stimulus_mc; expected values are hand-derived
// from the channel sequencer timing (FETCH bubble, WAIT countdown, wrap rules).
module tb_oh_stimulus_mc;
  import oh_stimulus_mc_pkg::*;

  localparam int NCH = 4, PW = 32, CW = 8, DEPTH = 16;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  oh_stimulus_mc_if #(.NCH(NCH), .PW(PW), .CW(CW)) bus ();

  oh_stimulus_mc #(.NCH(NCH), .PW(PW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [31:0] pay, input int d);
    bus.load_valid = 1'b1;
    bus.load_chan  = 2'(ch);
    bus.load_entry = {pay, 7'(d), 1'b1};
    tick;
    bus.load_valid = 1'b0;
  endtask

  task automatic clr;
    bus.mode = MODE_LOAD;
    bus.load_clear = 1'b1;
    tick;
    bus.load_clear = 1'b0;
  endtask

  task automatic test_reset;
    tick; tick;
    nvec++; if (bus.stim_valid !== 4'b0) begin nerr++; $display("FAIL rst_valid: got %b exp 0000", bus.stim_valid); end
    nvec++; if (bus.stim_packet !== '0) begin nerr++; $display("FAIL rst_packet: got %h exp 0", bus.stim_packet); end
    nvec++; if (bus.stim_done !== 4'b0) begin nerr++; $display("FAIL rst_done: got %b exp 0000", bus.stim_done); end
    nvec++; if (bus.load_full !== 4'b0) begin nerr++; $display("FAIL rst_full: got %b exp 0000", bus.load_full); end
    nvec++; if (bus.all_done !== 1'b0) begin nerr++; $display("FAIL rst_all_done: got %b exp 0", bus.all_done); end
    nreset = 1'b1;
    tick;
  endtask

  task automatic test_play_nodelay;
    logic exp_v;
    logic [3:0] exp_d;
    clr;
    wr(0, 32'hA0, 0); wr(0, 32'hA1, 0); wr(0, 32'hA2, 0);
    bus.stim_ready = 4'b1111;
    bus.mode = MODE_PLAY;
    tick;
    for (int c = 1; c <= 8; c++) begin
      tick;
      exp_v = (c == 1) || (c == 3) || (c == 5);
      exp_d = {3'b111, (c >= 7)};
      nvec++; if (bus.stim_valid[0] !== exp_v) begin nerr++; $display("FAIL play_valid c%0d: got %b exp %b", c, bus.stim_valid[0], exp_v); end
      if (exp_v) begin
        nvec++; if (bus.stim_packet[0 +: PW] !== 32'hA0 + 32'((c - 1) / 2)) begin nerr++; $display("FAIL play_pkt c%0d: got %h exp %h", c, bus.stim_packet[0 +: PW], 32'hA0 + 32'((c - 1) / 2)); end
      end
      nvec++; if (bus.stim_done !== exp_d) begin nerr++; $display("FAIL play_done c%0d: got %b exp %b", c, bus.stim_done, exp_d); end
      nvec++; if (bus.all_done !== (c >= 7)) begin nerr++; $display("FAIL play_all_done c%0d: got %b exp %b", c, bus.all_done, (c >= 7)); end
    end
    bus.mode = MODE_LOAD;
    tick;
  endtask

  task automatic test_delay_backpressure;
    clr;
    wr(2, 32'hC0, 5); wr(0, 32'hB0, 0);
    bus.stim_ready = 4'b1011;
    bus.mode = MODE_PLAY;
    tick;
    for (int c = 1; c <= 6; c++) begin
      tick;
      nvec++; if (bus.stim_valid[2] !== (c == 6)) begin nerr++; $display("FAIL dly_valid c%0d: got %b exp %b", c, bus.stim_valid[2], (c == 6)); end
    end
    nvec++; if (bus.stim_done[0] !== 1'b1) begin nerr++; $display("FAIL dly_ch0_done: got %b exp 1", bus.stim_done[0]); end
    for (int h = 0; h < 10; h++) begin
      tick;
      nvec++; if ({bus.stim_valid[2], bus.stim_packet[2*PW +: PW]} !== {1'b1, 32'hC0}) begin nerr++; $display("FAIL bp_hold h%0d: got %b/%h exp 1/c0", h, bus.stim_valid[2], bus.stim_packet[2*PW +: PW]); end
    end
    bus.stim_ready[2] = 1'b1;
    tick;
    nvec++; if (bus.stim_valid[2] !== 1'b0) begin nerr++; $display("FAIL bp_accept: got %b exp 0", bus.stim_valid[2]); end
    tick;
    nvec++; if (bus.stim_done !== 4'b1111) begin nerr++; $display("FAIL bp_done: got %b exp 1111", bus.stim_done); end
    bus.mode = MODE_LOAD;
    tick;
  endtask

  task automatic test_hold;
    clr;
    wr(2, 32'hD0, 5);
    bus.stim_ready = 4'b1011;
    bus.mode = MODE_PLAY;
    tick; tick; tick; tick;
    bus.mode = MODE_HOLD;
    for (int h = 0; h < 4; h++) begin
      tick;
      nvec++; if (bus.stim_valid[2] !== 1'b0) begin nerr++; $display("FAIL hold_wait h%0d: got %b exp 0", h, bus.stim_valid[2]); end
    end
    bus.mode = MODE_PLAY;
    for (int c = 1; c <= 3; c++) begin
      tick;
      nvec++; if (bus.stim_valid[2] !== (c == 3)) begin nerr++; $display("FAIL hold_resume c%0d: got %b exp %b", c, bus.stim_valid[2], (c == 3)); end
    end
    bus.mode = MODE_HOLD;
    #1;
    nvec++; if ({bus.stim_valid, bus.stim_packet} !== '0) begin nerr++; $display("FAIL hold_send: got %b/%h exp 0/0", bus.stim_valid, bus.stim_packet); end
    tick; tick;
    bus.mode = MODE_PLAY;
    #1;
    nvec++; if ({bus.stim_valid[2], bus.stim_packet[2*PW +: PW]} !== {1'b1, 32'hD0}) begin nerr++; $display("FAIL hold_send_resume: got %b/%h exp 1/d0", bus.stim_valid[2], bus.stim_packet[2*PW +: PW]); end
    bus.mode = MODE_LOAD;
    tick;
  endtask

  task automatic test_loop_wrap;
    int n = 0;
    clr;
    for (int i = 0; i < DEPTH; i++) wr(3, 32'h300 + 32'(i), 0);
    bus.stim_ready = 4'b1111;
    bus.mode = MODE_LOOP;
    for (int cyc = 0; cyc < 400 && n < 3 * DEPTH; cyc++) begin
      tick;
      nvec++; if (bus.stim_done !== 4'b0) begin nerr++; $display("FAIL loop_done cyc%0d: got %b exp 0000", cyc, bus.stim_done); end
      if (bus.stim_valid[3]) begin
        nvec++; if (bus.stim_packet[3*PW +: PW] !== 32'h300 + 32'(n % DEPTH)) begin nerr++; $display("FAIL loop_pkt n%0d: got %h exp %h", n, bus.stim_packet[3*PW +: PW], 32'h300 + 32'(n % DEPTH)); end
        n++;
      end
    end
    nvec++; if (n !== 3 * DEPTH) begin nerr++; $display("FAIL loop_count: got %0d exp %0d", n, 3 * DEPTH); end
    bus.mode = MODE_PLAY;
    #1;
    nvec++; if (bus.stim_done !== 4'b0111) begin nerr++; $display("FAIL loop_empty_done: got %b exp 0111", bus.stim_done); end
    bus.mode = MODE_LOAD;
    tick;
  endtask

  task automatic test_load_bounds;
    int n = 0;
    clr;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr(0, 32'h500 + 32'(i), 0);
      if (i == DEPTH - 2) begin
        nvec++; if (bus.load_full[0] !== 1'b0) begin nerr++; $display("FAIL full_early: got %b exp 0", bus.load_full[0]); end
      end
      if (i == DEPTH - 1) begin
        nvec++; if (bus.load_full[0] !== 1'b1) begin nerr++; $display("FAIL full_set: got %b exp 1", bus.load_full[0]); end
      end
    end
    nvec++; if (bus.load_full !== 4'b0001) begin nerr++; $display("FAIL full_vec: got %b exp 0001", bus.load_full); end
    bus.stim_ready = 4'b1111;
    bus.mode = MODE_PLAY;
    for (int cyc = 0; cyc < 100 && !bus.stim_done[0]; cyc++) begin
      tick;
      if (bus.stim_valid[0]) begin
        nvec++; if (bus.stim_packet[0 +: PW] !== 32'h500 + 32'(n)) begin nerr++; $display("FAIL full_pkt n%0d: got %h exp %h", n, bus.stim_packet[0 +: PW], 32'h500 + 32'(n)); end
        n++;
      end
    end
    nvec++; if (n !== DEPTH) begin nerr++; $display("FAIL full_count: got %0d exp %0d", n, DEPTH); end
    nvec++; if (bus.stim_done[0] !== 1'b1) begin nerr++; $display("FAIL full_wrap_done: got %b exp 1", bus.stim_done[0]); end
    bus.mode = MODE_LOAD;
    tick;
    clr;
    nvec++; if (bus.load_full !== 4'b0) begin nerr++; $display("FAIL clear_full: got %b exp 0000", bus.load_full); end
    bus.mode = MODE_PLAY;
    bus.load_valid = 1'b1;
    bus.load_chan  = 2'd0;
    bus.load_entry = {32'h77, 7'd0, 1'b1};
    for (int c = 0; c < DEPTH + 4; c++) begin
      tick;
      nvec++; if (bus.stim_valid[0] !== 1'b0) begin nerr++; $display("FAIL play_write c%0d: got %b exp 0", c, bus.stim_valid[0]); end
    end
    bus.load_valid = 1'b0;
    nvec++; if ({bus.load_full[0], bus.stim_done[0]} !== 2'b01) begin nerr++; $display("FAIL play_write_state: got %b exp 01", {bus.load_full[0], bus.stim_done[0]}); end
    bus.mode = MODE_LOAD;
    tick;
  endtask

  task automatic test_load_mid_run;
    clr;
    wr(0, 32'hE0, 0); wr(0, 32'hE1, 0);
    bus.stim_ready = 4'b1110;
    bus.mode = MODE_PLAY;
    tick; tick;
    nvec++; if ({bus.stim_valid[0], bus.stim_packet[0 +: PW]} !== {1'b1, 32'hE0}) begin nerr++; $display("FAIL mid_first: got %b/%h exp 1/e0", bus.stim_valid[0], bus.stim_packet[0 +: PW]); end
    bus.mode = MODE_LOAD;
    #1;
    nvec++; if ({bus.stim_valid, bus.stim_packet} !== '0) begin nerr++; $display("FAIL mid_load_drop: got %b/%h exp 0/0", bus.stim_valid, bus.stim_packet); end
    tick;
    bus.stim_ready = 4'b1111;
    bus.mode = MODE_PLAY;
    tick; tick;
    nvec++; if ({bus.stim_valid[0], bus.stim_packet[0 +: PW]} !== {1'b1, 32'hE0}) begin nerr++; $display("FAIL mid_restart: got %b/%h exp 1/e0", bus.stim_valid[0], bus.stim_packet[0 +: PW]); end
    bus.mode = MODE_LOAD;
    tick;
  endtask

  task automatic test_reset_mid_send;
    clr;
    wr(1, 32'hF1, 0);
    bus.stim_ready = 4'b1101;
    bus.mode = MODE_PLAY;
    tick; tick;
    nvec++; if ({bus.stim_valid[1], bus.stim_packet[PW +: PW]} !== {1'b1, 32'hF1}) begin nerr++; $display("FAIL rst_pre_send: got %b/%h exp 1/f1", bus.stim_valid[1], bus.stim_packet[PW +: PW]); end
    nreset = 1'b0;
    #1;
    nvec++; if ({bus.stim_valid, bus.stim_packet} !== '0) begin nerr++; $display("FAIL rst_mid_out: got %b/%h exp 0/0", bus.stim_valid, bus.stim_packet); end
    nvec++; if ({bus.stim_done, bus.all_done} !== 5'b0) begin nerr++; $display("FAIL rst_mid_done: got %b exp 00000", {bus.stim_done, bus.all_done}); end
    bus.mode = MODE_LOAD;
    tick;
    nreset = 1'b1;
    tick;
  endtask

  initial begin
    bus.mode       = MODE_LOAD;
    bus.load_valid = 1'b0;
    bus.load_chan  = '0;
    bus.load_entry = '0;
    bus.load_clear = 1'b0;
    bus.stim_ready = '0;
    test_reset;
    test_play_nodelay;
    test_delay_backpressure;
    test_hold;
    test_loop_wrap;
    test_load_bounds;
    test_load_mid_run;
    test_reset_mid_send;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
